// File: rtl/mem_access_unit.sv
// mem_access_unit: turns CPU byte/halfword/word loads and stores into word-wide RAM accesses.
// Optional macro MAU_ALIGN_CHECK_EN enables misaligned-access detection on addr_err.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        addr_err,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic [31:0] a_r;
  logic [2:0]  o_r;
  logic [31:0] d_r;
  logic [31:0] w_r;
  logic [31:0] rdata_r;
  logic        addr_err_r;
  logic        misalign_s;
  logic [7:0]  lane_byte_s;
  logic [15:0] lane_half_s;
  logic [31:0] load_s;
  logic [31:0] store_word_s;

`ifdef MAU_ALIGN_CHECK_EN
  // Alignment check of the live request, only consulted at acceptance
  always_comb begin
    misalign_s = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: misalign_s = addr[0];
      OP_LW, OP_SW:         misalign_s = (addr[1:0] != 2'b00);
      default:              misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          if (misalign_s) begin
            next_state_s = S_DONE;
          end else begin
            case (op)
              OP_SW:        next_state_s = S_WRITE;
              OP_SB, OP_SH: next_state_s = S_RMW_RD;
              default:      next_state_s = S_LOAD;
            endcase
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_LOAD:   next_state_s = S_DONE;
      S_RMW_RD: next_state_s = S_WRITE;
      S_WRITE:  next_state_s = S_DONE;
      S_DONE:   next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Load lane selection and sign/zero extension (little-endian lanes)
  always_comb begin
    lane_byte_s = 8'h00;
    lane_half_s = 16'h0000;
    load_s      = 32'h0000_0000;
    case (a_r[1:0])
      2'b00:   lane_byte_s = ram_rdata[7:0];
      2'b01:   lane_byte_s = ram_rdata[15:8];
      2'b10:   lane_byte_s = ram_rdata[23:16];
      2'b11:   lane_byte_s = ram_rdata[31:24];
      default: lane_byte_s = 8'h00;
    endcase
    if (a_r[1]) begin
      lane_half_s = ram_rdata[31:16];
    end else begin
      lane_half_s = ram_rdata[15:0];
    end
    case (o_r)
      OP_LB:   load_s = {{24{lane_byte_s[7]}}, lane_byte_s};
      OP_LBU:  load_s = {24'h00_0000, lane_byte_s};
      OP_LH:   load_s = {{16{lane_half_s[15]}}, lane_half_s};
      OP_LHU:  load_s = {16'h0000, lane_half_s};
      default: load_s = ram_rdata;
    endcase
  end

  // Store word merge: sub-word stores patch the word captured in RMW_RD
  always_comb begin
    store_word_s = d_r;
    case (o_r)
      OP_SB: begin
        store_word_s = w_r;
        case (a_r[1:0])
          2'b00:   store_word_s[7:0]   = d_r[7:0];
          2'b01:   store_word_s[15:8]  = d_r[7:0];
          2'b10:   store_word_s[23:16] = d_r[7:0];
          2'b11:   store_word_s[31:24] = d_r[7:0];
          default: store_word_s        = w_r;
        endcase
      end
      OP_SH: begin
        if (a_r[1]) begin
          store_word_s = {d_r[15:0], w_r[15:0]};
        end else begin
          store_word_s = {w_r[31:16], d_r[15:0]};
        end
      end
      default: store_word_s = d_r;
    endcase
  end

  // RAM-side drive: write data only in WRITE, live address only while idle
  always_comb begin
    ram_wdata = 32'h0000_0000;
    ram_addr  = {addr[31:2], 2'b00};
    if (state_r == S_WRITE) begin
      ram_wdata = store_word_s;
    end else begin
      ram_wdata = 32'h0000_0000;
    end
    if (state_r == S_IDLE) begin
      ram_addr = {addr[31:2], 2'b00};
    end else begin
      ram_addr = {a_r[31:2], 2'b00};
    end
  end

  // State, request latches, RMW word and load result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      a_r        <= 32'h0000_0000;
      o_r        <= 3'b000;
      d_r        <= 32'h0000_0000;
      w_r        <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      addr_err_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_IDLE && req) begin
        a_r        <= addr;
        o_r        <= op;
        d_r        <= wdata;
        addr_err_r <= misalign_s;
      end
      if (state_r == S_LOAD) begin
        rdata_r <= load_s;
      end
      if (state_r == S_RMW_RD) begin
        w_r <= ram_rdata;
      end
    end
  end

  // ram_we decodes straight from state so reset removes it without waiting for a clock
  assign ram_we   = (state_r == S_WRITE);
  assign done     = (state_r == S_DONE);
  assign busy     = (state_r != S_IDLE);
  assign rdata    = rdata_r;
  assign addr_err = addr_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, busy/reset sequences and random ops
// checked against a byte-array memory model. Honours MAU_ALIGN_CHECK_EN like the design.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s;
  logic [2:0]  op_s;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;
  logic [31:0] rdata_s;
  logic        done_s;
  logic        busy_s;
  logic        addr_err_s;
  logic        ram_we_s;
  logic [31:0] ram_addr_s;
  logic [31:0] ram_wdata_s;
  logic [31:0] ram_rdata_s;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int total = 0;
  int bad   = 0;

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req_s),
    .op        (op_s),
    .addr      (addr_s),
    .wdata     (wdata_s),
    .rdata     (rdata_s),
    .done      (done_s),
    .busy      (busy_s),
    .addr_err  (addr_err_s),
    .ram_we    (ram_we_s),
    .ram_addr  (ram_addr_s),
    .ram_wdata (ram_wdata_s),
    .ram_rdata (ram_rdata_s)
  );

  always #5 clk = ~clk;

  // Word RAM: combinational read, clocked write, plus a bench preload port
  assign ram_rdata_s = mem[ram_addr_s[7:2]];
  always @(posedge clk) begin
    if (ram_we_s) mem[ram_addr_s[7:2]] <= ram_wdata_s;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  // Reference byte memory and expected results
  logic [7:0]  rb [0:255];
  logic [31:0] m_rdata;
  logic        m_err;
  int          m_lat;
  int          m_we;

  typedef struct {
    logic        pre;
    logic [31:0] pre_word;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
    int          exp_we;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output int wec);
    @(negedge clk);
    req_s = 1'b1; op_s = o; addr_s = a; wdata_s = wd;
    @(posedge clk); #1;
    req_s = 1'b0;
    lat = 1;
    wec = ram_we_s ? 1 : 0;
    while (!done_s && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (ram_we_s) wec++;
    end
    rd = rdata_s;
    er = addr_err_s;
    @(posedge clk); #1;
    chk("done_single_then_idle", {30'b0, done_s, busy_s}, 32'h0);
  endtask

  function automatic logic [31:0] ref_word(input int wb);
    return {rb[wb+3], rb[wb+2], rb[wb+1], rb[wb]};
  endfunction

  // Expected outcome of one request, from byte-addressed memory semantics
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
    int ai, hb, wb, v;
    bit is_half, is_word, is_store, mis;
    ai = int'(a[7:0]);
    hb = ai - (ai % 2);
    wb = ai - (ai % 4);
    is_half  = (o == 3'd1 || o == 3'd5 || o == 3'd7);
    is_word  = (o == 3'd2 || o == 3'd3);
    is_store = (o == 3'd3 || o == 3'd6 || o == 3'd7);
    mis = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
    mis = (is_half && (ai % 2) != 0) || (is_word && (ai % 4) != 0);
`endif
    m_err = mis;
    m_we  = 0;
    if (mis) begin
      m_lat = 1;
    end else if (!is_store) begin
      m_lat = 2;
      case (o)
        3'd0: begin v = int'(rb[ai]); if (v > 127) v -= 256; m_rdata = v; end
        3'd4: begin v = int'(rb[ai]); m_rdata = v; end
        3'd1: begin v = int'(rb[hb]) + 256 * int'(rb[hb+1]); if (v > 32767) v -= 65536; m_rdata = v; end
        3'd5: begin v = int'(rb[hb]) + 256 * int'(rb[hb+1]); m_rdata = v; end
        default: m_rdata = ref_word(wb);
      endcase
    end else begin
      m_lat = (o == 3'd3) ? 2 : 3;
      m_we  = 1;
      case (o)
        3'd6: rb[ai] = wd[7:0];
        3'd7: begin rb[hb] = wd[7:0]; rb[hb+1] = wd[15:8]; end
        default: for (int k = 0; k < 4; k++) rb[wb+k] = wd[8*k +: 8];
      endcase
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, wec, dcnt, wcnt;
  logic [8:0]  dpat, wpat;
  logic [31:0] rv;

  initial begin
    reset = 1'b1; req_s = 1'b0; op_s = 3'd0; addr_s = 32'h0; wdata_s = 32'h0;
    pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdata_s, 32'h0);
    chk("reset_ctl", {28'b0, done_s, busy_s, addr_err_s, ram_we_s}, 32'h0);
    chk("reset_ram_wdata", ram_wdata_s, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    addr_s = 32'h1234_5677;
    #1;
    chk("idle_ram_addr_live", ram_addr_s, 32'h1234_5674);

    tbl[0]  = '{1'b1, 32'h8899AABB, 3'd0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 32'h8899AABB, 0};
    tbl[1]  = '{1'b0, 32'h0, 3'd4, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 32'h8899AABB, 0};
    tbl[2]  = '{1'b0, 32'h0, 3'd1, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 32'h8899AABB, 0};
    tbl[3]  = '{1'b0, 32'h0, 3'd5, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 32'h8899AABB, 0};
    tbl[4]  = '{1'b0, 32'h0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 32'h8899AABB, 0};
    tbl[5]  = '{1'b0, 32'h0, 3'd6, 32'h13, 32'h12345677, 32'h8899AABB, 1'b0, 3, 32'h7799AABB, 1};
    tbl[6]  = '{1'b1, 32'h8899AABB, 3'd7, 32'h10, 32'hFFFF1234, 32'h8899AABB, 1'b0, 3, 32'h88991234, 1};
    tbl[7]  = '{1'b0, 32'h0, 3'd3, 32'h10, 32'hDEADBEEF, 32'h8899AABB, 1'b0, 2, 32'hDEADBEEF, 1};
`ifdef MAU_ALIGN_CHECK_EN
    tbl[8]  = '{1'b0, 32'h0, 3'd2, 32'h12, 32'h0, 32'h8899AABB, 1'b1, 1, 32'hDEADBEEF, 0};
    tbl[9]  = '{1'b0, 32'h0, 3'd7, 32'h11, 32'hAAAA5555, 32'h8899AABB, 1'b1, 1, 32'hDEADBEEF, 0};
`else
    tbl[8]  = '{1'b0, 32'h0, 3'd2, 32'h12, 32'h0, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF, 0};
    tbl[9]  = '{1'b0, 32'h0, 3'd7, 32'h11, 32'hAAAA5555, 32'hDEADBEEF, 1'b0, 3, 32'hDEAD5555, 1};
`endif
    tbl[10] = '{1'b1, 32'h7F00807F, 3'd0, 32'h10, 32'h0, 32'h0000007F, 1'b0, 2, 32'h7F00807F, 0};
    tbl[11] = '{1'b0, 32'h0, 3'd1, 32'h10, 32'h0, 32'hFFFF807F, 1'b0, 2, 32'h7F00807F, 0};

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].pre) preload(4, tbl[i].pre_word);
      do_op(tbl[i].op, tbl[i].addr, tbl[i].wd, rd, er, lat, wec);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_addr_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_we_cycles", i), wec, tbl[i].exp_we);
      chk($sformatf("vec%0d_ram_word", i), mem[4], tbl[i].exp_word);
    end

    // Busy handling: SB accepted, then SW held on req throughout
    preload(12, 32'h01020304);
    @(negedge clk);
    req_s = 1'b1; op_s = 3'd6; addr_s = 32'h30; wdata_s = 32'h000000AB;
    @(posedge clk); #1;
    op_s = 3'd3; addr_s = 32'h34; wdata_s = 32'h55667788;
    dpat = 9'b0; wpat = 9'b0;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      dpat[j] = done_s;
      wpat[j] = ram_we_s;
      if (j == 5) req_s = 1'b0;
    end
    chk("busy_done_pattern", {23'b0, dpat}, {23'b0, 9'b000100100});
    chk("busy_we_pattern", {23'b0, wpat}, {23'b0, 9'b000010010});
    chk("busy_sb_word", mem[12], 32'h010203AB);
    chk("busy_sw_word", mem[13], 32'h55667788);

    // Random ops against the byte model
    for (int i = 0; i < 64; i++) begin
      rv = $urandom;
      preload(i, rv);
      for (int k = 0; k < 4; k++) rb[4*i+k] = rv[8*k +: 8];
    end
    m_rdata = tbl[NV-1].exp_rd;
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] a, wd;
      o  = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      model_op(o, a, wd);
      do_op(o, a, wd, rd, er, lat, wec);
      chk($sformatf("rnd%0d_rdata", i), rd, m_rdata);
      chk($sformatf("rnd%0d_addr_err", i), 32'(er), 32'(m_err));
      chk($sformatf("rnd%0d_latency", i), lat, m_lat);
      chk($sformatf("rnd%0d_we_cycles", i), wec, m_we);
      chk($sformatf("rnd%0d_ram_word", i), mem[a[7:2]], ref_word(int'({a[7:2], 2'b00})));
    end

    // Reset during RMW_RD of an SB
    preload(8, 32'h11223344);
    @(negedge clk);
    req_s = 1'b1; op_s = 3'd6; addr_s = 32'h21; wdata_s = 32'h000000FF;
    @(posedge clk); #1;
    req_s = 1'b0;
    chk("rst_rmw_busy_before", 32'(busy_s), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_rmw_rdata", rdata_s, 32'h0);
    chk("rst_rmw_ctl", {28'b0, done_s, busy_s, addr_err_s, ram_we_s}, 32'h0);
    chk("rst_rmw_ram_wdata", ram_wdata_s, 32'h0);
    dcnt = 0; wcnt = 0;
    repeat (2) begin @(posedge clk); #1; dcnt += int'(done_s); wcnt += int'(ram_we_s); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; dcnt += int'(done_s); wcnt += int'(ram_we_s); end
    chk("rst_rmw_no_done", dcnt, 0);
    chk("rst_rmw_no_we", wcnt, 0);
    chk("rst_rmw_ram_word", mem[8], 32'h11223344);

    // Reset in the WRITE cycle must pull ram_we down at once
    @(negedge clk);
    req_s = 1'b1; op_s = 3'd3; addr_s = 32'h20; wdata_s = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_s = 1'b0;
    chk("rst_wr_we_before", 32'(ram_we_s), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_we_async", 32'(ram_we_s), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ram_word", mem[8], 32'h11223344);
    chk("rst_wr_no_done", 32'(done_s), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
